spart_tx: RTL and testbench

Serial transmitter stage of the SPART. It consumes the single-cycle `start` pulse produced by the rising-edge detector on the processor's transmit-enable line, latches a byte, and shifts it out on `txd` as an asynchronous 8-N-1 frame (8-E-1 when parity is compiled in). The bit rate comes from a programmable per-bit clock divisor. The block reports `busy` while a frame is in flight and a one-cycle `done` when it completes.

---
 rtl/spart_pkg.sv | 24 ++
 rtl/spart_baud_cnt.sv | 28 ++
 rtl/spart_tx.sv | 118 +++++++++++
 tb/tb_spart_tx.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared SPART types and constants: transmitter FSM states, frame levels
// and the even-parity helper. Build option: SPART_TX_PARITY_EN.
package spart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef SPART_TX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } tx_state_t;

  function automatic logic even_par(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/spart_baud_cnt.sv
// Bit-period counter shared by the SPART transmitter and receiver.
// Ports: clk, rst (sync, high), clr, divisor -> bit_tick on last cycle of a bit.
module spart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] divisor,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt;

  // Counts 0..divisor, so one bit lasts divisor+1 cycles.
  assign bit_tick = (cnt == divisor);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spart_tx.sv
// SPART serial transmitter: 8-N-1 frames (8-E-1 with SPART_TX_PARITY_EN).
// Ports: clk, rst (sync, high), start, tx_data, divisor -> txd, busy, done.
module spart_tx
  import spart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       tx_data,
  input  logic [DIV_W-1:0] divisor,
  output logic             txd,
  output logic             busy,
  output logic             done
);

  tx_state_t              state;
  logic [DATA_BITS-1:0]   shift;
  logic [DIV_W-1:0]       div_q;
  logic [2:0]             bit_cnt;
  logic                   bit_tick;
  logic                   clr;
`ifdef SPART_TX_PARITY_EN
  logic [DATA_BITS-1:0]   data_q;
`endif

  // Counter idles at zero so a new frame's first bit is full length.
  assign clr = (state == IDLE);

  spart_baud_cnt #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .divisor  (div_q),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      txd     <= STOP_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
      shift   <= '0;
      div_q   <= '0;
      bit_cnt <= '0;
`ifdef SPART_TX_PARITY_EN
      data_q  <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shift   <= tx_data;
            div_q   <= divisor;
            bit_cnt <= '0;
`ifdef SPART_TX_PARITY_EN
            data_q  <= tx_data;
`endif
            state   <= START;
            txd     <= START_LEVEL;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            state <= DATA;
            txd   <= shift[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= shift >> 1;
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef SPART_TX_PARITY_EN
              state <= PARITY;
              txd   <= even_par(data_q);
`else
              state <= STOP;
              txd   <= STOP_LEVEL;
`endif
            end else begin
              // Next bit is shift[1]: the shift lands this same edge.
              txd <= shift[1];
            end
          end
        end
`ifdef SPART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            state <= STOP;
            txd   <= STOP_LEVEL;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            state <= IDLE;
            txd   <= STOP_LEVEL;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= STOP_LEVEL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spart_tx.sv
// Directed self-checking bench for spart_tx.
// Frames are checked bit by bit against hand-written bit lists.
module tb_spart_tx;

`ifdef SPART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  tx_data;
  logic [15:0] divisor;
  logic        txd;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_bad;

  logic cap_txd  [0:127];
  logic cap_busy [0:127];
  logic cap_done [0:127];

  spart_tx #(
    .DIV_W (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_data (tx_data),
    .divisor (divisor),
    .txd     (txd),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called #1 after a posedge; returns #1 into cycle N+1.
  task automatic kick(input logic [7:0] d, input logic [15:0] dv);
    tx_data = d;
    divisor = dv;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    tx_data = ~d;
    divisor = dv + 16'd5;
  endtask

  // Records outputs at the negedge of the next n cycles.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_txd[i]  = txd;
      cap_busy[i] = busy;
      cap_done[i] = done;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    tx_data = 8'h00;
    divisor = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp += 3;
      if (txd !== 1'b1) begin
        n_bad++;
        $display("FAIL reset txd[%0d]: got %b want 1", i, txd);
      end
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset busy[%0d]: got %b want 0", i, busy);
      end
      if (done !== 1'b0) begin
        n_bad++;
        $display("FAIL reset done[%0d]: got %b want 0", i, done);
      end
    end
  endtask

  task automatic test_single;
    logic e [0:10];
    int   p;
`ifdef SPART_TX_PARITY_EN
    e = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    e = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
    p = 4;
    @(posedge clk);
    #1 kick(8'hA5, 16'd3);
    capture(FL * p + 2);
    for (int b = 0; b < FL; b++) begin
      for (int k = 0; k < p; k++) begin
        n_cmp += 3;
        if (cap_txd[b*p+k] !== e[b]) begin
          n_bad++;
          $display("FAIL single txd bit%0d cyc%0d: got %b want %b",
                   b, k, cap_txd[b*p+k], e[b]);
        end
        if (cap_busy[b*p+k] !== 1'b1) begin
          n_bad++;
          $display("FAIL single busy bit%0d: got %b want 1",
                   b, cap_busy[b*p+k]);
        end
        if (cap_done[b*p+k] !== 1'b0) begin
          n_bad++;
          $display("FAIL single early done bit%0d: got %b want 0",
                   b, cap_done[b*p+k]);
        end
      end
    end
    n_cmp += 4;
    if (cap_done[FL*p] !== 1'b1) begin
      n_bad++;
      $display("FAIL single done: got %b want 1", cap_done[FL*p]);
    end
    if (cap_busy[FL*p] !== 1'b0) begin
      n_bad++;
      $display("FAIL single busy end: got %b want 0", cap_busy[FL*p]);
    end
    if (cap_txd[FL*p] !== 1'b1) begin
      n_bad++;
      $display("FAIL single txd end: got %b want 1", cap_txd[FL*p]);
    end
    if (cap_done[FL*p+1] !== 1'b0) begin
      n_bad++;
      $display("FAIL single done width: got %b want 0", cap_done[FL*p+1]);
    end
  endtask

  task automatic test_back_to_back;
    logic e0 [0:10];
    logic e1 [0:10];
    e0 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
`ifdef SPART_TX_PARITY_EN
    e1 = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
`else
    e1 = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
    // On the idle line a zero-length gap still applies: frame 0 stop bit
    // at index 9 is 1 (non-parity); with parity index 9 is parity 0.
`ifndef SPART_TX_PARITY_EN
    e0[9] = 1'b1;
`endif
    @(posedge clk);
    #1 kick(8'h00, 16'd0);
    capture(FL);
    for (int b = 0; b < FL; b++) begin
      n_cmp++;
      if (cap_txd[b] !== e0[b]) begin
        n_bad++;
        $display("FAIL b2b f0 txd bit%0d: got %b want %b",
                 b, cap_txd[b], e0[b]);
      end
    end
    @(posedge clk);
    #1;
    tx_data = 8'hFF;
    divisor = 16'd0;
    start   = 1'b1;
    @(negedge clk);
    n_cmp += 3;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b f0 done: got %b want 1", done);
    end
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b f0 busy end: got %b want 0", busy);
    end
    if (txd !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b f0 txd end: got %b want 1", txd);
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    tx_data = 8'h00;
    capture(FL + 2);
    for (int b = 0; b < FL; b++) begin
      n_cmp += 2;
      if (cap_txd[b] !== e1[b]) begin
        n_bad++;
        $display("FAIL b2b f1 txd bit%0d: got %b want %b",
                 b, cap_txd[b], e1[b]);
      end
      if (cap_busy[b] !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b f1 busy bit%0d: got %b want 1", b, cap_busy[b]);
      end
    end
    n_cmp += 2;
    if (cap_done[FL] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b f1 done: got %b want 1", cap_done[FL]);
    end
    if (cap_done[FL+1] !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b f1 done width: got %b want 0", cap_done[FL+1]);
    end
  endtask

  task automatic test_ignored_start;
    logic e [0:10];
    int   p;
    int   nd;
`ifdef SPART_TX_PARITY_EN
    e = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
`else
    e = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
`endif
    p = 2;
    @(posedge clk);
    #1 kick(8'h3C, 16'd1);
    fork
      capture(FL * p + 3);
      begin
        repeat (8) @(posedge clk);
        #1;
        start   = 1'b1;
        tx_data = 8'hFF;
        divisor = 16'd0;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    for (int b = 0; b < FL; b++) begin
      for (int k = 0; k < p; k++) begin
        n_cmp++;
        if (cap_txd[b*p+k] !== e[b]) begin
          n_bad++;
          $display("FAIL ignored txd bit%0d cyc%0d: got %b want %b",
                   b, k, cap_txd[b*p+k], e[b]);
        end
      end
    end
    nd = 0;
    for (int i = 0; i < FL * p + 3; i++) begin
      if (cap_done[i] === 1'b1) nd++;
    end
    n_cmp += 2;
    if (nd != 1) begin
      n_bad++;
      $display("FAIL ignored done count: got %0d want 1", nd);
    end
    if (cap_done[FL*p] !== 1'b1) begin
      n_bad++;
      $display("FAIL ignored done pos: got %b want 1", cap_done[FL*p]);
    end
  endtask

  task automatic test_reset_mid;
    logic e [0:10];
    int   p;
`ifdef SPART_TX_PARITY_EN
    e = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1};
`else
    e = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
`endif
    @(posedge clk);
    #1 kick(8'h5A, 16'd3);
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp += 3;
    if (txd !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid txd: got %b want 1", txd);
    end
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid busy: got %b want 0", busy);
    end
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid done: got %b want 0", done);
    end
    capture(8);
    for (int i = 0; i < 8; i++) begin
      n_cmp += 2;
      if (cap_done[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid late done[%0d]: got %b want 0", i, cap_done[i]);
      end
      if (cap_busy[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL rstmid late busy[%0d]: got %b want 0", i, cap_busy[i]);
      end
    end
    @(posedge clk);
    #1;
    rst     = 1'b1;
    start   = 1'b1;
    tx_data = 8'h00;
    divisor = 16'd0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    capture(4);
    for (int i = 0; i < 4; i++) begin
      n_cmp += 2;
      if (cap_busy[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL rst+start busy[%0d]: got %b want 0", i, cap_busy[i]);
      end
      if (cap_txd[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL rst+start txd[%0d]: got %b want 1", i, cap_txd[i]);
      end
    end
    p = 3;
    @(posedge clk);
    #1 kick(8'hC3, 16'd2);
    capture(FL * p + 1);
    for (int b = 0; b < FL; b++) begin
      for (int k = 0; k < p; k++) begin
        n_cmp++;
        if (cap_txd[b*p+k] !== e[b]) begin
          n_bad++;
          $display("FAIL rstmid next txd bit%0d cyc%0d: got %b want %b",
                   b, k, cap_txd[b*p+k], e[b]);
        end
      end
    end
    n_cmp++;
    if (cap_done[FL*p] !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid next done: got %b want 1", cap_done[FL*p]);
    end
  endtask

  task automatic test_min_frame;
    logic e [0:10];
    // 8'h07 has three ones, so the even-parity bit (index 9) is 1.
    e = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    @(posedge clk);
    #1 kick(8'h07, 16'd0);
    capture(FL + 2);
    for (int b = 0; b < FL; b++) begin
      n_cmp++;
      if (cap_txd[b] !== e[b]) begin
        n_bad++;
        $display("FAIL min txd bit%0d: got %b want %b", b, cap_txd[b], e[b]);
      end
    end
    n_cmp += 3;
    if (cap_done[FL-1] !== 1'b0) begin
      n_bad++;
      $display("FAIL min early done: got %b want 0", cap_done[FL-1]);
    end
    if (cap_done[FL] !== 1'b1) begin
      n_bad++;
      $display("FAIL min done: got %b want 1", cap_done[FL]);
    end
    if (cap_busy[FL] !== 1'b0) begin
      n_bad++;
      $display("FAIL min busy end: got %b want 0", cap_busy[FL]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    start = 1'b0;
    tx_data = 8'h00;
    divisor = 16'd0;
    test_reset;
    test_single;
    test_back_to_back;
    test_ignored_start;
    test_reset_mid;
    test_min_frame;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
